// File: rtl/pipe_ctrl_pkg.sv
// Shared HOLD_BUS encodings and FSM state type for the pipeline hold/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned HOLD_BUS_W  = 3;
  localparam int unsigned INST_ADDR_W = 32;

  // Encodings must stay aligned with the HOLD_BUS values in defines.v
  localparam logic [HOLD_BUS_W-1:0] HOLD_NONE  = 3'd0;
  localparam logic [HOLD_BUS_W-1:0] HOLD_PC    = 3'd1;
  localparam logic [HOLD_BUS_W-1:0] HOLD_IF_ID = 3'd2;
  localparam logic [HOLD_BUS_W-1:0] HOLD_ID_EX = 3'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLUSH     = 2'd1,
    STALL_EX  = 2'd2,
    STALL_BUS = 2'd3
  } pipe_ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Free-running flush/stall cycle counters; wrap at 2^CNT_W, synchronous active-low clear.
module pipe_ctrl_perf #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_cyc_i,
  input  logic             stall_cyc_i,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush_cyc_i) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (stall_cyc_i) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign flush_cnt_o = r_flush_cnt;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: merges jump, EX-busy and bus-wait into hold_flag_o and PC redirect.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   jump_req_i,
  input  logic [INST_ADDR_W-1:0] jump_addr_i,
  input  logic                   ex_hold_req_i,
  input  logic                   bus_hold_req_i,
  output logic [HOLD_BUS_W-1:0]  hold_flag_o,
  output logic                   jump_flag_o,
  output logic [INST_ADDR_W-1:0] jump_addr_o,
  output logic                   stall_timeout_o,
  output logic [CNT_W-1:0]       flush_cnt_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT + 1);
  localparam int unsigned REM_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam bit          FLUSH_EN = (FLUSH_CYCLES > 1);
  localparam logic [REM_W-1:0]   REM_LOAD  = REM_W'(FLUSH_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_TIMEOUT);

  pipe_ctrl_state_e r_state, w_state_d, w_rest_state;
  logic [REM_W-1:0]   r_flush_rem, w_flush_rem_d;
  logic [STALL_W-1:0] r_stall_cnt, w_stall_cnt_d;
  logic               r_timeout;
  logic               w_in_flush, w_flush_cyc, w_stall_cyc;

  assign w_in_flush  = (r_state == FLUSH);
  assign w_flush_cyc = jump_req_i | w_in_flush;
  // A stall cycle is one whose hold comes from ex/bus, not from a jump or flush
  assign w_stall_cyc = ~w_flush_cyc & (ex_hold_req_i | bus_hold_req_i);

  always_comb begin
    w_rest_state = IDLE;
    if (ex_hold_req_i)       w_rest_state = STALL_EX;
    else if (bus_hold_req_i) w_rest_state = STALL_BUS;
  end

  always_comb begin
    w_state_d     = w_rest_state;
    w_flush_rem_d = '0;
    if (jump_req_i) begin
      if (FLUSH_EN) begin
        w_state_d     = FLUSH;
        w_flush_rem_d = REM_LOAD;
      end
    end else if (w_in_flush && (r_flush_rem > REM_W'(1))) begin
      w_state_d     = FLUSH;
      w_flush_rem_d = r_flush_rem - REM_W'(1);
    end
  end

  always_comb begin
    w_stall_cnt_d = '0;
    if (w_stall_cyc) begin
      w_stall_cnt_d = (r_stall_cnt == STALL_MAX) ? r_stall_cnt : r_stall_cnt + STALL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_flush_rem <= '0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_flush_rem <= w_flush_rem_d;
      r_stall_cnt <= w_stall_cnt_d;
      if (w_stall_cnt_d == STALL_MAX) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    hold_flag_o = HOLD_NONE;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    if (jump_req_i) begin
      hold_flag_o = HOLD_ID_EX;
      jump_flag_o = 1'b1;
      jump_addr_o = jump_addr_i;
    end else if (w_in_flush || ex_hold_req_i) begin
      hold_flag_o = HOLD_ID_EX;
    end else if (bus_hold_req_i) begin
      hold_flag_o = HOLD_PC;
    end
  end

  assign stall_timeout_o = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_cyc_i(w_flush_cyc),
    .stall_cyc_i(w_stall_cyc),
    .flush_cnt_o(flush_cnt_o),
    .stall_cnt_o(stall_cnt_o)
  );
`else
  assign flush_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule
